// File: rtl/pixel_streamer_if.sv
// Pixel streamer bus bundle: the frame-memory read port and the 8-bit
// pixel strobe output toward the 2D filter.
interface pixel_streamer_if #(
  parameter int AW = 16
);
  logic          mem_cs;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_dout;
  logic          o_strb;
  logic [7:0]    o_data;

  // Driven by the streamer.
  modport master (
    output mem_cs,
    output mem_addr,
    output o_strb,
    output o_data,
    input  mem_dout
  );

  // Frame memory and filter side.
  modport slave (
    input  mem_cs,
    input  mem_addr,
    input  o_strb,
    input  o_data,
    output mem_dout
  );
endinterface

// File: rtl/pixel_streamer.sv
// Pixel streamer: reads one WIDTH x WIDTH frame from a synchronous frame
// memory in raster order and emits one pixel strobe every INTERVAL cycles,
// optionally followed by WIDTH+1 zero strobes to drain the filter.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// SLOT  | one pixel slot per INTERVAL cycles, memory read at s=0
// FLUSH | zero-valued strobes, same slot timing, no memory access
// FIN   | one-cycle done pulse, busy drops on exit
module pixel_streamer #(
  parameter int WIDTH    = 256,
  parameter int INTERVAL = 8,
  parameter int AW       = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             flush_en,
  input  logic             i_hold,
  output logic             busy,
  output logic             done,
  pixel_streamer_if.master bus
);

  localparam int NPIX = WIDTH * WIDTH;
  localparam int FW   = $clog2(WIDTH) + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SLOT  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [7:0]    LAST_S   = 8'(INTERVAL - 1);
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
  localparam logic [FW-1:0] LAST_FL  = FW'(WIDTH);

  // Parameter sanity: the filter needs at least 7 cycles per pixel and the
  // slot counter is 8 bits wide.
  if (INTERVAL < 7 || INTERVAL > 255) begin : g_bad_interval
    $fatal(1, "pixel_streamer: INTERVAL=%0d outside 7..255", INTERVAL);
  end
  if (WIDTH < 4 || WIDTH > 256 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "pixel_streamer: WIDTH=%0d must be a power of two in 4..256", WIDTH);
  end
  if (AW != $clog2(NPIX)) begin : g_bad_aw
    $fatal(1, "pixel_streamer: AW=%0d does not match log2(WIDTH*WIDTH)", AW);
  end

  logic [1:0]    state;
  logic [7:0]    s;
  logic [AW-1:0] pix;
  logic [AW-1:0] addr_hold;
  logic [FW-1:0] fl_cnt;
  logic          flush_flag;

  logic slot_active;
  logic at_start;
  logic stall;
  logic slot_end;
  logic read_now;

  // Slot-phase decode shared by the FSM, the memory port and the output stage.
  always_comb begin
    slot_active = (state == SLOT) || (state == FLUSH);
    at_start    = (s == 8'd0);
    stall       = slot_active && at_start && i_hold;
    slot_end    = slot_active && (s == LAST_S);
    read_now    = (state == SLOT) && at_start && !i_hold;
  end

  // The memory read is issued in the slot-start cycle itself; the address
  // mux keeps mem_addr stable between reads so the memory sees no toggling.
  assign bus.mem_cs   = read_now;
  assign bus.mem_addr = read_now ? pix : addr_hold;

  // Remember the last issued address for the idle hold value.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      addr_hold <= '0;
    end else if (read_now) begin
      addr_hold <= pix;
    end
  end

  // Main sequencer: frame start, slot counter, pixel and flush counters.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      s          <= 8'd0;
      pix        <= '0;
      fl_cnt     <= '0;
      flush_flag <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SLOT;
            flush_flag <= flush_en;
            busy       <= 1'b1;
            pix        <= '0;
            fl_cnt     <= '0;
            s          <= 8'd0;
          end
        end

        SLOT: begin
          if (!stall) begin
            if (slot_end) begin
              s <= 8'd0;
              // pix is held on the last pixel so no address past the frame
              // is ever presented; it is cleared on the way out through FIN.
              if (pix == LAST_PIX) begin
                if (flush_flag) begin
                  state <= FLUSH;
                end else begin
                  state <= FIN;
                  done  <= 1'b1;
                end
              end else begin
                pix <= pix + AW'(1);
              end
            end else begin
              s <= s + 8'd1;
            end
          end
        end

        FLUSH: begin
          if (!stall) begin
            if (slot_end) begin
              s <= 8'd0;
              if (fl_cnt == LAST_FL) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                fl_cnt <= fl_cnt + FW'(1);
              end
            end else begin
              s <= s + 8'd1;
            end
          end
        end

        FIN: begin
          state  <= IDLE;
          busy   <= 1'b0;
          pix    <= '0;
          fl_cnt <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output stage: memory data arrives during s=1, so the strobe is launched
  // on the edge ending s=1 and is high for exactly one cycle (s=2).
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus.o_strb <= 1'b0;
      bus.o_data <= 8'd0;
    end else begin
      bus.o_strb <= 1'b0;
      if (slot_active && (s == 8'd1)) begin
        bus.o_strb <= 1'b1;
        bus.o_data <= (state == SLOT) ? bus.mem_dout : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer (WIDTH=4, INTERVAL=8).
`timescale 1ns/1ps
module tb_pixel_streamer;
  localparam int W     = 4;
  localparam int IV    = 8;
  localparam int AW    = 4;
  localparam int NPIX  = W * W;
  localparam int SCHED = 8192;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic start = 1'b0;
  logic flush_en = 1'b0;
  logic i_hold = 1'b0;
  logic busy;
  logic done;

  pixel_streamer_if #(.AW(AW)) bus ();

  pixel_streamer #(.WIDTH(W), .INTERVAL(IV), .AW(AW)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (start),
    .flush_en (flush_en),
    .i_hold   (i_hold),
    .busy     (busy),
    .done     (done),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous frame memory model.
  logic [7:0] mem [0:NPIX-1];
  always @(posedge clk) if (bus.mem_cs) bus.mem_dout <= mem[bus.mem_addr];

  // Scoreboard state.
  int  exp_data_q[$];
  int  exp_strb_cyc_q[$];
  int  exp_addr_q[$];
  int  exp_cs_cyc_q[$];
  int  done_cyc = -1;
  int  busy_lo = 0;
  int  busy_hi = -1;
  int  last_addr = 0;
  bit  hold_sched [SCHED];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int target);
    if (cyc > target) begin
      checks++;
      errors++;
      $display("FAIL schedule: at cycle %0d expected to be no later than %0d", cyc, target);
    end
    while (cyc < target) tick();
  endtask

  // Reference model: slot k starts at the first non-held cycle at or after its
  // nominal start; the read happens there, the strobe two cycles later, and the
  // next slot's nominal start is INTERVAL cycles after the actual start.
  task automatic launch(input bit fl, input bit rnd);
    int c, t, slots;
    c = cyc;
    for (int i = 0; i < NPIX; i++) mem[i] = rnd ? 8'($urandom) : 8'(i + 1);
    start    = 1'b1;
    flush_en = fl;
    slots    = NPIX + (fl ? W + 1 : 0);
    t        = c + 1;
    for (int k = 0; k < slots; k++) begin
      while (t < SCHED - 1 && hold_sched[t]) t++;
      if (k < NPIX) begin
        exp_addr_q.push_back(k);
        exp_cs_cyc_q.push_back(t);
        exp_data_q.push_back(int'(mem[k]));
      end else begin
        exp_data_q.push_back(0);
      end
      exp_strb_cyc_q.push_back(t + 2);
      t += IV;
    end
    busy_lo  = c + 1;
    busy_hi  = t;
    done_cyc = t;
    tick();
    start    = 1'b0;
    flush_en = ~fl;
  endtask

  task automatic wait_frame();
    goto(done_cyc + 2);
    check("leftover_strobes", exp_data_q.size(), 0);
    check("leftover_reads", exp_addr_q.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_o_strb"}, bus.o_strb, 0);
    check({tag, "_o_data"}, bus.o_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_cs"}, bus.mem_cs, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
  endtask

  // Hold driver: i_hold follows the precomputed schedule, one value per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_hold = (cyc < SCHED) ? hold_sched[cyc] : 1'b0;
    end
  end

  // Monitor: compare every observed output against the scoreboard.
  initial begin
    int a;
    forever begin
      @(negedge clk);
      if (n_reset) begin
        if (bus.o_strb) begin
          if (exp_data_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: data %0d at cycle %0d, none expected", bus.o_data, cyc);
          end else begin
            check("strobe_data", bus.o_data, exp_data_q.pop_front());
            check("strobe_cycle", cyc, exp_strb_cyc_q.pop_front());
          end
        end
        if (bus.mem_cs) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: addr %0d at cycle %0d, none expected", bus.mem_addr, cyc);
          end else begin
            a = exp_addr_q.pop_front();
            check("read_addr", bus.mem_addr, a);
            check("read_cycle", cyc, exp_cs_cyc_q.pop_front());
            last_addr = a;
          end
        end else begin
          check("addr_hold", bus.mem_addr, last_addr);
        end
        check("done", done, (cyc == done_cyc));
        check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, st, len;

    // Reset values.
    tick();
    tick();
    #3;
    check_quiet("reset");
    tick();
    n_reset = 1'b1;
    tick();
    tick();

    // Plain frame, ramp data, no flush.
    launch(1'b0, 1'b0);
    wait_frame();

    // Same frame with flush tail.
    launch(1'b1, 1'b0);
    wait_frame();

    // Hold spanning pixel 5's slot start, plus a mid-slot hold that must not matter.
    c = cyc;
    for (int i = 0; i < 10; i++) hold_sched[c + 1 + 5 * IV + i] = 1'b1;
    for (int i = 0; i < 4; i++) hold_sched[c + 1 + 2 * IV + 3 + i] = 1'b1;
    launch(1'b0, 1'b1);
    wait_frame();

    // Start while busy and start during done are ignored; start right after done is taken.
    c = cyc;
    launch(1'b0, 1'b1);
    goto(c + 1 + 7 * IV + 2);
    start    = 1'b1;
    flush_en = 1'b1;
    tick();
    start    = 1'b0;
    goto(done_cyc);
    start    = 1'b1;
    flush_en = 1'b1;
    tick();
    launch(1'b0, 1'b1);
    wait_frame();

    // Reset in the middle of a frame.
    c = cyc;
    launch(1'b1, 1'b1);
    goto(c + 1 + 9 * IV + 3);
    n_reset = 1'b0;
    exp_data_q.delete();
    exp_strb_cyc_q.delete();
    exp_addr_q.delete();
    exp_cs_cyc_q.delete();
    done_cyc  = -1;
    busy_hi   = -1;
    last_addr = 0;
    #3;
    check_quiet("midreset");
    tick();
    tick();
    n_reset = 1'b1;
    tick();
    tick();
    launch(1'b0, 1'b1);
    wait_frame();

    // Randomised frames with random hold bursts.
    for (int f = 0; f < 4; f++) begin
      c = cyc;
      for (int b = 0; b < 4; b++) begin
        st  = c + 1 + $urandom_range(0, NPIX * IV - 1);
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) hold_sched[st + i] = 1'b1;
      end
      launch(1'($urandom_range(0, 1)), 1'b1);
      wait_frame();
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
- Transmit side of the 8-bit pixel strobe interface consumed by the 2D filter: reads one WIDTH x WIDTH frame from a single-port synchronous frame memory in raster order and emits it as o_strb/o_data, one pixel per INTERVAL cycles.
- Optionally appends zero-valued flush strobes so the filter drains its last row.
- Sits between the frame buffer and filter2d input; controlled by a start pulse from the host/testbench.

Parameters:
- WIDTH, 256, frame is WIDTH x WIDTH pixels; power of two, 4..256.
- INTERVAL, 8, cycles between consecutive o_strb pulses. Legal range 7..255, since the filter needs >=7 cycles per pixel. Out of range is a simulation-time fatal error.
- AW, 16, memory address width = log2(WIDTH*WIDTH).

Ports:
- clk  input  1  clock, rising edge
- n_reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to stream one frame; ignored while busy=1
- flush_en  input  1  sampled with start; 1 = append WIDTH+1 zero strobes after the frame
- i_hold  input  1  pause request; sampled only at slot start
- mem_cs  output  1  frame memory read enable
- mem_addr  output  AW  frame memory read address, raster index y*WIDTH+x
- mem_dout  input  8  memory read data, valid the cycle after mem_cs
- o_strb  output  1  one-cycle pixel strobe
- o_data  output  8  pixel value; changes only on the edge that raises o_strb
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse at end of frame (and flush)

Behaviour:
- Reset values: all outputs 0; state IDLE; pixel counter 0; interval counter 0; flush flag 0.
- States:
  - IDLE: start=1 -> SLOT; latch flush_en; busy<=1; pix<=0.
  - SLOT: slot-cycle counter s runs 0..INTERVAL-1.
    - At s=0 with i_hold=1: stay at s=0; no mem_cs; counter frozen.
    - At s=0 with i_hold=0: mem_cs=1, mem_addr=pix.
    - At s=1: o_data<=mem_dout and o_strb<=1, so o_strb is high during s=2.
    - At s=INTERVAL-1: pix<=pix+1. If pix==WIDTH*WIDTH-1, go to FLUSH if the flush flag is set, else to FIN.
  - FLUSH: same slot timing and same i_hold rule, but no mem_cs; o_data<=0 with o_strb at s=2. Runs WIDTH+1 slots, then FIN.
  - FIN: done=1 for one cycle; busy<=0; -> IDLE.
- Latency: start sampled at edge E0. mem_cs is high in the cycle after E0. First o_strb is high 2 cycles later. Strobe k rises at E0 + 2 + k*INTERVAL edges, with no holds.
- mem_cs is combinational from state and s, one cycle wide. mem_addr holds its last value when mem_cs=0.
- o_strb never high in two consecutive cycles. Spacing is exactly INTERVAL with no holds, and INTERVAL + hold cycles otherwise.
- i_hold mid-slot (s!=0) has no effect until the next slot start.
- start while busy: ignored, with no effect on flush flag or counters. start in the same cycle as done: ignored. start in IDLE on the cycle after done: accepted.
- pix wraps only via the FIN transition; no address beyond WIDTH*WIDTH-1 is issued.
- Reset mid-frame returns immediately to reset values. A partially emitted frame is abandoned and no done is issued.
- flush_en changes during a frame have no effect; only the value latched at start is used.

Test Plan:
- WIDTH=4, INTERVAL=8, memory[i]=i+1, start, flush_en=0 -> 16 strobes with o_data 1..16. Strobe k high at cycle 3+8k after the start edge. done 1 cycle after the last slot ends; busy high for 16*8+1 cycles.
- Same as above with flush_en=1 -> 16 data strobes then 5 strobes with o_data=0, no mem_cs during flush, done after slot 21.
- i_hold=1 for 10 cycles spanning the slot-start of pixel 5 -> pixel 5 strobe delayed by exactly 10 cycles. Later spacing is back to 8; o_data sequence unchanged.
- start pulsed again at pixel 7 and in the cycle done=1 -> both ignored; exactly one frame emitted. start one cycle after done -> second frame begins.
- n_reset low for 2 cycles at pixel 9 -> o_strb, busy, done, mem_cs all 0. Next start restarts from mem_addr 0.
- WIDTH=256, INTERVAL=7, driven into filter2d with the default kernel, uniform image of 100, two frames -> filter output frame 2 interior pixels = 100, strobe count 65536.
